// File: rtl/gnr_sim_ctrl.sv
// Drives an array of GNR node cells: loads an initial vector and steps the network.
// After every step it samples both tap vectors and streams them out over a valid/ready port.
module gnr_sim_ctrl #(
    parameter int unsigned N_NODES       = 8,
    parameter int unsigned STEP_W        = 16,
    parameter int unsigned S0_PULSES     = 2,
    parameter bit          STOP_ON_FIXED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] init_state,
    input  logic [STEP_W-1:0]  num_steps,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_vec,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] apc_s0,
    input  logic [N_NODES-1:0] apc_s1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_NODES-1:0] out_s0,
    output logic [N_NODES-1:0] out_s1,
    output logic [STEP_W-1:0]  out_step,
    output logic               out_fixed,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PC_W = (S0_PULSES > 1) ? $clog2(S0_PULSES) : 1;

    typedef enum logic [2:0] {
        IDLE, INIT, CAPTURE, EMIT, PH_S0, PH_S1, DONE
    } state_t;

    state_t             state, state_d;
    logic [STEP_W-1:0]  step, step_d;
    logic [STEP_W-1:0]  num_lat, num_lat_d;
    logic [PC_W-1:0]    pcnt, pcnt_d;
    logic [N_NODES-1:0] prev_s0, prev_s0_d, prev_s1, prev_s1_d;
    logic [N_NODES-1:0] init_vec_d, out_s0_d, out_s1_d;
    logic [STEP_W-1:0]  out_step_d;
    logic               out_valid_d, out_fixed_d;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        step_d      = step;
        num_lat_d   = num_lat;
        pcnt_d      = '0;
        prev_s0_d   = prev_s0;
        prev_s1_d   = prev_s1;
        init_vec_d  = '0;
        out_s0_d    = out_s0;
        out_s1_d    = out_s1;
        out_step_d  = out_step;
        out_valid_d = out_valid;
        out_fixed_d = out_fixed;

        unique case (state)
            IDLE: begin
                if (start) begin
                    num_lat_d  = num_steps;
                    init_vec_d = init_state;
                    step_d     = '0;
                    state_d    = INIT;
                end
            end
            INIT: state_d = CAPTURE;
            CAPTURE: begin
                out_s0_d    = apc_s0;
                out_s1_d    = apc_s1;
                out_step_d  = step;
                out_fixed_d = (step != '0) && (apc_s0 == prev_s0) && (apc_s1 == prev_s1);
                prev_s0_d   = apc_s0;
                prev_s1_d   = apc_s1;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                // Terminal compare precedes increment so the step counter never wraps
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if ((step == num_lat) || (STOP_ON_FIXED && out_fixed)) begin
                        state_d = DONE;
                    end else begin
                        step_d  = step + STEP_W'(1);
                        state_d = PH_S0;
                    end
                end
            end
            PH_S0: begin
                if (pcnt == PC_W'(S0_PULSES - 1)) begin
                    state_d = PH_S1;
                end else begin
                    pcnt_d = pcnt + PC_W'(1);
                end
            end
            PH_S1:   state_d = CAPTURE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they coincide with that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            num_lat   <= '0;
            pcnt      <= '0;
            prev_s0   <= '0;
            prev_s1   <= '0;
            reset_nos <= 1'b0;
            init_vec  <= '0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            out_valid <= 1'b0;
            out_s0    <= '0;
            out_s1    <= '0;
            out_step  <= '0;
            out_fixed <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            num_lat   <= num_lat_d;
            pcnt      <= pcnt_d;
            prev_s0   <= prev_s0_d;
            prev_s1   <= prev_s1_d;
            reset_nos <= (state_d == INIT);
            init_vec  <= init_vec_d;
            start_s0  <= (state_d == PH_S0);
            start_s1  <= (state_d == PH_S1);
            out_valid <= out_valid_d;
            out_s0    <= out_s0_d;
            out_s1    <= out_s1_d;
            out_step  <= out_step_d;
            out_fixed <= out_fixed_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

endmodule
